matrix_frame_capture: RTL and testbench

- Receive-side model of the 16x16 LED matrix shift-register interface (RCLK, RSDI, CSDI, CCLK, LE, OEB) that the pong core drives.
- Samples those pins in the system clock domain and reconstructs the displayed frame into a 16x16 buffer.
- The buffer is readable one row at a time.
- Flags protocol errors.
- Used on-chip for self-test/loopback via the logic analyzer, and as the scoreboard in the bench.

---
 rtl/matrix_frame_capture.sv | 173 +++++++++++++++++
 tb/tb_matrix_frame_capture.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_frame_capture.sv
// Receive-side capture of the 16x16 LED matrix shift-register interface.
// Synchronizes the six driver pins into clk, detects rising edges of the
// shift/latch clocks, and rebuilds the displayed frame into a 16-row
// buffer. The buffer has a registered read port. Protocol errors are
// reported through sticky flags.
module matrix_frame_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int COLS        = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RCLK,
    input  logic            RSDI,
    input  logic            CCLK,
    input  logic            CSDI,
    input  logic            LE,
    input  logic            OEB,
    input  logic [3:0]      rd_row,
    output logic [COLS-1:0] rd_data,
    output logic            frame_done,
    output logic [7:0]      frame_count,
    output logic            row_err,
    output logic            len_err,
    output logic            blank_seen
);

    localparam int IW = $clog2(COLS);

    // Pin order inside the synchronizer vector.
    localparam int P_RCLK = 0;
    localparam int P_RSDI = 1;
    localparam int P_CCLK = 2;
    localparam int P_CSDI = 3;
    localparam int P_LE   = 4;
    localparam int P_OEB  = 5;

    logic [5:0]      pins_in;
    logic [5:0]      sync_q [SYNC_STAGES];
    logic [2:0]      prev_q;          // {LE, CCLK, RCLK} history for edge detect

    logic            rclk_s, rsdi_s, cclk_s, csdi_s, le_s, oeb_s;
    logic            rclk_rise, cclk_rise, le_rise;

    logic [COLS-1:0] col_sr, row_sr;
    logic [4:0]      bit_cnt;

    logic [COLS-1:0] col_next, row_next;
    logic [4:0]      cnt_next;
    logic            row_onehot;
    logic [IW-1:0]   row_idx;

    logic [COLS-1:0] frame_buf [COLS];

    assign pins_in = {OEB, LE, CSDI, CCLK, RSDI, RCLK};

    // Multi-flop synchronizer chain for all six driver pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // stage samples the value its predecessor held before the edge.
            sync_q[0] <= pins_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rclk_s = sync_q[SYNC_STAGES-1][P_RCLK];
    assign rsdi_s = sync_q[SYNC_STAGES-1][P_RSDI];
    assign cclk_s = sync_q[SYNC_STAGES-1][P_CCLK];
    assign csdi_s = sync_q[SYNC_STAGES-1][P_CSDI];
    assign le_s   = sync_q[SYNC_STAGES-1][P_LE];
    assign oeb_s  = sync_q[SYNC_STAGES-1][P_OEB];

    // Edge-detect history for the three driver clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= {le_s, cclk_s, rclk_s};
        end
    end

    assign rclk_rise = rclk_s & ~prev_q[0];
    assign cclk_rise = cclk_s & ~prev_q[1];
    assign le_rise   = le_s   & ~prev_q[2];

    // Post-shift register values, so a latch in the same cycle as a shift
    // sees the newly shifted data and bit count.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise an untaken path would hold its value and infer a latch.
        col_next = col_sr;
        row_next = row_sr;
        cnt_next = bit_cnt;
        if (cclk_rise) begin
            col_next = {col_sr[COLS-2:0], csdi_s};
            cnt_next = (bit_cnt == 5'd31) ? bit_cnt : bit_cnt + 5'd1;
        end
        if (rclk_rise) begin
            row_next = {row_sr[COLS-2:0], rsdi_s};
        end
    end

    // One-hot test and index of the selected row.
    always_comb begin
        row_onehot = (row_next != '0) && ((row_next & (row_next - COLS'(1))) == '0);
        row_idx    = '0;
        for (int i = 0; i < COLS; i++) begin
            if (row_next[i]) begin
                row_idx = IW'(i);
            end
        end
    end

    // Shift registers, bit counter, frame accounting and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_sr      <= '0;
            row_sr      <= '0;
            bit_cnt     <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            row_err     <= 1'b0;
            len_err     <= 1'b0;
            blank_seen  <= 1'b0;
        end else begin
            col_sr     <= col_next;
            row_sr     <= row_next;
            blank_seen <= blank_seen | oeb_s;
            frame_done <= 1'b0;
            if (le_rise) begin
                // A shift coinciding with the latch starts the next row's count.
                bit_cnt <= cclk_rise ? 5'd1 : 5'd0;
                if (!row_onehot) begin
                    row_err <= 1'b1;
                end
                if (cnt_next != 5'(COLS)) begin
                    len_err <= 1'b1;
                end
                if (row_onehot && (row_idx == IW'(COLS-1))) begin
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 8'd1;
                end
            end else begin
                bit_cnt <= cnt_next;
            end
        end
    end

    // Frame buffer write on a valid latch, and registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the buffer is part of the reset domain so that a reset
            // always reads back as an empty frame; this is why it is a loop
            // of flops rather than an un-reset RAM.
            for (int i = 0; i < COLS; i++) begin
                frame_buf[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (le_rise && row_onehot) begin
                frame_buf[row_idx] <= col_next;
            end
            rd_data <= frame_buf[rd_row];
        end
    end

endmodule

// File: tb/tb_matrix_frame_capture.sv
// Testbench for matrix_frame_capture: drives the pin protocol with random
// data and hold times. A reference model tracks the frame, flags and
// counters. Readback is checked through a scoreboard queue.
module tb_matrix_frame_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        RCLK, RSDI, CCLK, CSDI, LE, OEB;
    logic [3:0]  rd_row;
    logic [15:0] rd_data;
    logic        frame_done;
    logic [7:0]  frame_count;
    logic        row_err, len_err, blank_seen;

    matrix_frame_capture #(.SYNC_STAGES(2), .COLS(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .RCLK       (RCLK),
        .RSDI       (RSDI),
        .CCLK       (CCLK),
        .CSDI       (CSDI),
        .LE         (LE),
        .OEB        (OEB),
        .rd_row     (rd_row),
        .rd_data    (rd_data),
        .frame_done (frame_done),
        .frame_count(frame_count),
        .row_err    (row_err),
        .len_err    (len_err),
        .blank_seen (blank_seen)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_buf [16];
    bit          m_col_q[$];      // last 16 column bits, oldest first
    bit          m_row_q[$];      // last 16 row bits, oldest first
    int          m_ccnt;          // CCLK edges since last latch
    bit          m_row_err, m_len_err, m_blank;
    int          m_frames;        // frames since reset
    int          m_pulses;        // frame_done pulses over the whole run

    function automatic logic [15:0] q_value(input bit q[$]);
        int v = 0;
        for (int i = 0; i < q.size(); i++) v = v * 2 + int'(q[i]);
        return 16'(v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_buf[i] = '0;
        m_col_q.delete();
        m_row_q.delete();
        m_ccnt    = 0;
        m_row_err = 0;
        m_len_err = 0;
        m_blank   = 0;
        m_frames  = 0;
    endtask

    task automatic model_col_bit(input bit d);
        m_col_q.push_back(d);
        if (m_col_q.size() > 16) void'(m_col_q.pop_front());
        m_ccnt++;
    endtask

    task automatic model_row_bit(input bit d);
        m_row_q.push_back(d);
        if (m_row_q.size() > 16) void'(m_row_q.pop_front());
    endtask

    task automatic model_latch(input bit same_cycle_cclk);
        logic [15:0] col, row;
        int cnt, r;
        col = q_value(m_col_q);
        row = q_value(m_row_q);
        cnt = (m_ccnt > 31) ? 31 : m_ccnt;
        if ($countones(row) == 1) begin
            r = 0;
            for (int i = 0; i < 16; i++) if (row[i]) r = i;
            m_buf[r] = col;
            if (r == 15) begin
                m_frames++;
                m_pulses++;
            end
        end else begin
            m_row_err = 1;
        end
        if (cnt != 16) m_len_err = 1;
        m_ccnt = same_cycle_cclk ? 1 : 0;
    endtask

    // ---------------- scoreboard and monitors ----------------
    typedef struct {
        string       name;
        logic [15:0] exp;
    } sb_entry_t;

    sb_entry_t exp_q[$];
    logic      rd_req   = 1'b0;
    logic      rd_req_d = 1'b0;
    int        fd_cycles = 0;

    always @(posedge clk) rd_req_d <= rd_req;

    always @(negedge clk) begin
        sb_entry_t e;
        if (rd_req_d) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: read data 0x%0h with no expected entry", rd_data);
            end else begin
                e = exp_q.pop_front();
                check(e.name, 32'(rd_data), 32'(e.exp));
            end
        end
    end

    always @(negedge clk) if (frame_done === 1'b1) fd_cycles++;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- drivers (called at negedge) ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold();
        wait_cyc(int'($urandom_range(2, 4)));
    endtask

    task automatic cclk_pulse(input bit d);
        CSDI = d;
        hold();
        CCLK = 1'b1;
        model_col_bit(d);
        hold();
        CCLK = 1'b0;
        hold();
    endtask

    task automatic rclk_pulse(input bit d);
        RSDI = d;
        hold();
        RCLK = 1'b1;
        model_row_bit(d);
        hold();
        RCLK = 1'b0;
        hold();
    endtask

    task automatic shift_word(input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) cclk_pulse(w[i]);
    endtask

    task automatic le_pulse();
        LE = 1'b1;
        model_latch(1'b0);
        hold();
        LE = 1'b0;
        hold();
    endtask

    task automatic cclk_le_pulse(input bit d);
        CSDI = d;
        hold();
        CCLK = 1'b1;
        LE   = 1'b1;
        model_col_bit(d);
        model_latch(1'b1);
        hold();
        CCLK = 1'b0;
        LE   = 1'b0;
        hold();
    endtask

    task automatic read_row(input int r, input string tag);
        sb_entry_t e;
        rd_row = 4'(r);
        rd_req = 1'b1;
        e.name = $sformatf("%s_row%0d", tag, r);
        e.exp  = m_buf[r];
        exp_q.push_back(e);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic read_all(input string tag);
        for (int r = 0; r < 16; r++) read_row(r, tag);
        wait_cyc(2);
        check({tag, "_sb_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_row_err"},     32'(row_err),     32'(m_row_err));
        check({tag, "_len_err"},     32'(len_err),     32'(m_len_err));
        check({tag, "_blank_seen"},  32'(blank_seen),  32'(m_blank));
        check({tag, "_frame_count"}, 32'(frame_count), 32'(m_frames % 256));
        check({tag, "_fd_cycles"},   32'(fd_cycles),   32'(m_pulses));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] w;
        logic [15:0] lat_k3, lat_k4;
        reset = 1'b1;
        {RCLK, RSDI, CCLK, CSDI, LE, OEB} = '0;
        rd_row = '0;
        model_reset();
        m_pulses = 0;
        wait_cyc(3);

        // Reset state
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check_flags("rst");
        reset = 1'b0;
        wait_cyc(2);

        // 1: single row with latency and same-cycle read/write ordering
        rclk_pulse(1'b1);
        shift_word(16'hA5C3, 16);
        rd_row = 4'd0;
        LE = 1'b1;
        model_latch(1'b0);
        lat_k3 = '0;
        lat_k4 = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 3) lat_k3 = rd_data;
            if (k == 4) lat_k4 = rd_data;
        end
        check("t1_read_old_in_write_cycle", 32'(lat_k3), 32'd0);
        check("t1_read_new_next_cycle", 32'(lat_k4), 32'(m_buf[0]));
        check("t1_model_row0", 32'(m_buf[0]), 32'hA5C3);
        LE = 1'b0;
        hold();
        check_flags("t1");

        // 2: full frame, OEB high throughout
        OEB = 1'b1;
        m_blank = 1;
        for (int r = 0; r < 16; r++) begin
            if (r > 0) rclk_pulse(1'b0);
            w = 16'h0101;
            w = w << (r % 8);
            shift_word(w, 16);
            le_pulse();
        end
        OEB = 1'b0;
        hold();
        read_all("t2");
        check_flags("t2");

        // 3: short row (15 bits) into row 2, then a full row
        rclk_pulse(1'b1);
        rclk_pulse(1'b0);
        rclk_pulse(1'b0);
        w = 16'($urandom);
        shift_word(w, 15);
        le_pulse();
        check_flags("t3_short");
        read_row(2, "t3_short");
        w = 16'($urandom);
        shift_word(w, 16);
        le_pulse();
        check_flags("t3_full");
        read_row(2, "t3_full");
        wait_cyc(2);

        // 4: non-one-hot row registers (0x0003, then 0x0000)
        for (int i = 0; i < 14; i++) rclk_pulse(1'b0);
        rclk_pulse(1'b1);
        rclk_pulse(1'b1);
        w = 16'($urandom);
        shift_word(w, 16);
        le_pulse();
        check_flags("t4_two_hot");
        read_all("t4_two_hot");
        for (int i = 0; i < 16; i++) rclk_pulse(1'b0);
        le_pulse();
        check_flags("t4_zero");
        read_all("t4_zero");

        // 6a: reset in the middle of a row
        rd_row = 4'd5;
        w = 16'($urandom);
        shift_word(w, 8);
        CSDI = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        check("t6_rst_rd_data", 32'(rd_data), 32'd0);
        check("t6_rst_frame_done", 32'(frame_done), 32'd0);
        check_flags("t6_rst");
        @(negedge clk);
        reset = 1'b0;
        wait_cyc(2);
        rclk_pulse(1'b1);
        w = 16'($urandom);
        shift_word(w, 16);
        le_pulse();
        check_flags("t6_clean");
        read_all("t6_clean");

        // 5: 16th CCLK edge coincides with LE, into row 1
        rclk_pulse(1'b0);
        w = 16'($urandom);
        shift_word(w >> 1, 15);
        cclk_le_pulse(w[0]);
        check_flags("t5");
        read_row(1, "t5");
        wait_cyc(2);

        // 6b: 256 frames wrap frame_count
        for (int i = 0; i < 14; i++) rclk_pulse(1'b0);
        for (int i = 0; i < 255; i++) le_pulse();
        check_flags("t6_255");
        le_pulse();
        check_flags("t6_wrap");
        read_row(15, "t6_wrap");
        wait_cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
